tx_stream_cipher: RTL

Parametrised TX datapath stage that XORs an AXI-Stream payload with a ChaCha20 keystream and emits framed ciphertext. It buffers 512-bit keystream blocks from the cipher core, slices them into DATA_W words and requests each block by counter value. It adds tlast/start-of-frame handling, per-frame counter restart, and correct backpressure. It sits between the TX AXI-lite register slave and the downstream AXI-Stream sink.

---
 rtl/tx_pkg.sv | 24 ++
 rtl/tx_ks_buffer.sv | 109 ++++++++++
 rtl/tx_stream_cipher.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared types and helpers for the TX stream-cipher datapath.
package tx_pkg;

    localparam int KS_BLK_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } tx_state_e;

    // Number of stream words carried by one keystream block.
    function automatic int words_per_blk(input int data_w);
        return KS_BLK_W / data_w;
    endfunction

    // Width of the word index; at least one bit even for a single-word block.
    function automatic int word_idx_w(input int data_w);
        int words;
        words = KS_BLK_W / data_w;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/tx_ks_buffer.sv
// Keystream block buffer: stores the current block, walks the word index and,
// when TX_STREAM_CIPHER_PREFETCH_EN is defined, fetches the next block early.
module tx_ks_buffer
    import tx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                i_aclk,
    input  logic                i_areset,
    input  logic                i_fill,
    input  logic                i_ks_valid,
    input  logic [KS_BLK_W-1:0] i_ks_block,
    input  logic                i_consume,
    input  logic                i_flush,
    output logic [DATA_W-1:0]   o_word,
    output logic                o_word_avail,
    output logic                o_last_word,
    output logic                o_pf_req,
    output logic                o_next_ready
);

    localparam int WORDS_PER_BLK = words_per_blk(DATA_W);
    localparam int IDX_W         = word_idx_w(DATA_W);

    logic [KS_BLK_W-1:0]                   cur_blk;
    logic [WORDS_PER_BLK-1:0][DATA_W-1:0]  cur_words;
    logic                                  cur_valid;
    logic [IDX_W-1:0]                      idx;
    logic                                  load_cur;
    logic                                  blk_done;

    assign cur_words    = cur_blk;
    assign o_word       = cur_words[idx];
    assign o_word_avail = cur_valid;
    assign o_last_word  = (idx == IDX_W'(WORDS_PER_BLK - 1));
    assign load_cur     = i_fill && i_ks_valid;
    assign blk_done     = i_consume && o_last_word && !i_flush;

`ifdef TX_STREAM_CIPHER_PREFETCH_EN
    logic [KS_BLK_W-1:0] nxt_blk;
    logic                nxt_valid;
    logic                pf_load;

    assign o_pf_req     = cur_valid && !nxt_valid;
    assign pf_load      = o_pf_req && i_ks_valid;
    assign o_next_ready = nxt_valid || pf_load;

    // Valid flags and word index; a finished block is replaced by the prefetched one.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            idx       <= '0;
        end else if (i_flush) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            idx       <= '0;
        end else if (load_cur) begin
            cur_valid <= 1'b1;
            idx       <= '0;
        end else if (blk_done) begin
            cur_valid <= o_next_ready;
            nxt_valid <= 1'b0;
            idx       <= '0;
        end else begin
            if (pf_load)   nxt_valid <= 1'b1;
            if (i_consume) idx <= idx + IDX_W'(1);
        end
    end

    // Block payload registers; meaning comes from the valid flags only.
    // NOTE: wide data registers carry no reset; their valid flags gate every use.
    always_ff @(posedge i_aclk) begin
        if (load_cur)
            cur_blk <= i_ks_block;
        else if (blk_done)
            cur_blk <= nxt_valid ? nxt_blk : i_ks_block;
        if (pf_load)
            nxt_blk <= i_ks_block;
    end
`else
    assign o_pf_req     = 1'b0;
    assign o_next_ready = 1'b0;

    // Valid flag and word index; a finished block simply empties the buffer.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            cur_valid <= 1'b0;
            idx       <= '0;
        end else if (i_flush || blk_done) begin
            cur_valid <= 1'b0;
            idx       <= '0;
        end else if (load_cur) begin
            cur_valid <= 1'b1;
            idx       <= '0;
        end else if (i_consume) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Block payload register, written only when a requested block arrives.
    always_ff @(posedge i_aclk) begin
        if (load_cur)
            cur_blk <= i_ks_block;
    end
`endif

endmodule

// File: rtl/tx_stream_cipher.sv
// TX stream-cipher stage: XORs AXI-Stream payload with ChaCha20 keystream words,
// requesting blocks by counter and framing output with sof/tlast.
// Optional macro TX_STREAM_CIPHER_PREFETCH_EN adds a second block buffer so
// block boundaries inside a frame cost no bubble.
module tx_stream_cipher
    import tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTR_W  = 32
) (
    input  logic                i_aclk,
    input  logic                i_areset,
    input  logic                i_enable,
    input  logic [CTR_W-1:0]    i_counter_init,
    output logic                o_ks_req,
    output logic [CTR_W-1:0]    o_ks_counter,
    input  logic                i_ks_valid,
    input  logic [KS_BLK_W-1:0] i_ks_block,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tlast,
    output logic                m_axis_sof,
    output logic                o_busy,
    output logic                o_ctr_wrap
);

    tx_state_e          state_q, state_d;
    logic [CTR_W-1:0]   ctr_q;
    logic               sof_pending_q;
    logic               wrap_q;

    logic [DATA_W-1:0]  ks_word;
    logic               word_avail, last_word, pf_req, next_ready;
    logic               accept, frame_end, blk_end, abort, fill, reload;

    assign s_axis_tready = (state_q == ST_RUN) && word_avail && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign frame_end     = accept && s_axis_tlast;
    assign blk_end       = accept && !s_axis_tlast && last_word;
    // Dropping enable before the first beat of a frame abandons the pending request.
    assign abort         = (state_q == ST_REQ) && !i_enable && sof_pending_q;
    assign fill          = (state_q == ST_REQ) && !abort;
    assign reload        = ((state_q == ST_IDLE) || frame_end) && i_enable;

    tx_ks_buffer #(.DATA_W(DATA_W)) u_ks_buffer (
        .i_aclk       (i_aclk),
        .i_areset     (i_areset),
        .i_fill       (fill),
        .i_ks_valid   (i_ks_valid),
        .i_ks_block   (i_ks_block),
        .i_consume    (accept),
        .i_flush      (frame_end),
        .o_word       (ks_word),
        .o_word_avail (word_avail),
        .o_last_word  (last_word),
        .o_pf_req     (pf_req),
        .o_next_ready (next_ready)
    );

    // State register.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_enable) state_d = ST_REQ;
            ST_REQ: begin
                if (abort)           state_d = ST_IDLE;
                else if (i_ks_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (frame_end)                  state_d = i_enable ? ST_REQ : ST_IDLE;
                else if (blk_end && !next_ready) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Block counter, start-of-frame flag and sticky wrap flag.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            ctr_q         <= '0;
            sof_pending_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else if (reload) begin
            ctr_q         <= i_counter_init;
            sof_pending_q <= 1'b1;
        end else begin
            if (accept) sof_pending_q <= 1'b0;
            if (blk_end) begin
                ctr_q <= ctr_q + CTR_W'(1);
                if (&ctr_q) wrap_q <= 1'b1;
            end
        end
    end

    // Output register: load on an accepted beat, hold while stalled, clear when drained.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_sof    <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata ^ ks_word;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_sof    <= sof_pending_q;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign o_ks_req     = (state_q == ST_REQ) || pf_req;
    assign o_ks_counter = pf_req ? (ctr_q + CTR_W'(1)) : ctr_q;
    assign o_busy       = (state_q != ST_IDLE) || m_axis_tvalid;
    assign o_ctr_wrap   = wrap_q;

endmodule
